matrix_host_if: RTL and testbench



---
 rtl/macc_pkg.sv | 13 +
 rtl/macc_elem_cnt.sv | 28 ++
 rtl/matrix_host_if.sv | 104 ++++++++++
 tb/tb_matrix_host_if.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/macc_pkg.sv
// Shared types and constants for the matrix host front end and its element counter.
package macc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UNLOAD = 2'd2
  } host_state_t;

  // Deepest the control block's read buffer can ever get.
  localparam logic [1:0] RB_DEPTH = 2'd2;

endpackage

// File: rtl/macc_elem_cnt.sv
// Loadable element down-counter; `last` flags the final element of a pass.
module macc_elem_cnt #(
  parameter int CNT_MSB = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_MSB:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_MSB:0] cnt;

  // NOTE: state is only ever written with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - {{CNT_MSB{1'b0}}, 1'b1};
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/matrix_host_if.sv
// Host-side front end: sequences config, element load and element unload for one matrix
// and turns valid/ready handshakes into single-cycle we/re pulses for the control block.
module matrix_host_if
  import macc_pkg::*;
#(
  parameter int DATA_MSB         = 15,
  parameter int MAT_IDX_SIZE_MSB = 3,
  parameter int CNT_MSB          = 2 * MAT_IDX_SIZE_MSB + 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cfg_valid,
  input  logic [MAT_IDX_SIZE_MSB:0] cfg_row_idx_size,
  input  logic [MAT_IDX_SIZE_MSB:0] cfg_col_idx_size,
  output logic                      cfg_ready,
  input  logic                      s_valid,
  input  logic [DATA_MSB:0]         s_data,
  output logic                      s_ready,
  output logic                      m_valid,
  output logic [DATA_MSB:0]         m_data,
  input  logic                      m_ready,
  input  logic [1:0]                rb_cnt,
  input  logic [DATA_MSB:0]         rb_data,
  output logic                      we,
  output logic                      re,
  output logic [DATA_MSB:0]         wr_data,
  output logic [MAT_IDX_SIZE_MSB:0] row_idx_size,
  output logic [MAT_IDX_SIZE_MSB:0] col_idx_size,
  output logic                      busy,
  output logic                      done
);

  host_state_t      state;
  logic             cfg_hs, wr_hs, rd_hs;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [CNT_MSB:0] cnt_load_val;

  // Element count minus one; the product wraps to exactly N-1 even for the largest matrix.
  function automatic logic [CNT_MSB:0] elems_m1(input logic [MAT_IDX_SIZE_MSB:0] r,
                                                input logic [MAT_IDX_SIZE_MSB:0] c);
    logic [CNT_MSB:0] one, rows, cols;
    one  = {{CNT_MSB{1'b0}}, 1'b1};
    rows = {{(CNT_MSB - MAT_IDX_SIZE_MSB){1'b0}}, r} + one;
    cols = {{(CNT_MSB - MAT_IDX_SIZE_MSB){1'b0}}, c} + one;
    return rows * cols - one;
  endfunction

  assign cfg_ready = (state == IDLE);
  assign s_ready   = (state == LOAD);
  assign m_valid   = (state == UNLOAD) && (rb_cnt != 2'd0);
  assign busy      = (state != IDLE);

  assign cfg_hs  = cfg_valid & cfg_ready;
  assign wr_hs   = s_valid & s_ready;
  assign rd_hs   = m_valid & m_ready;

  assign we      = wr_hs;
  assign re      = rd_hs;
  assign wr_data = s_data;
  assign m_data  = rb_data;

  // One counter serves both passes; LOAD end reloads it from the captured sizes.
  assign cnt_load     = cfg_hs | (wr_hs & cnt_last);
  assign cnt_dec      = wr_hs | rd_hs;
  assign cnt_load_val = (state == IDLE) ? elems_m1(cfg_row_idx_size, cfg_col_idx_size)
                                        : elems_m1(row_idx_size, col_idx_size);

  macc_elem_cnt #(.CNT_MSB(CNT_MSB)) u_elem_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      row_idx_size <= '0;
      col_idx_size <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cfg_hs) begin
          row_idx_size <= cfg_row_idx_size;
          col_idx_size <= cfg_col_idx_size;
          state        <= LOAD;
        end
        LOAD: if (wr_hs && cnt_last) state <= UNLOAD;
        UNLOAD: if (rd_hs && cnt_last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_rb_cnt_range: assert property (@(posedge CLK) disable iff (RST) rb_cnt <= RB_DEPTH);
  a_we_re_excl:   assert property (@(posedge CLK) disable iff (RST) !(we && re));

endmodule

// File: tb/tb_matrix_host_if.sv
// Directed self-checking bench for matrix_host_if with hand-computed expectations.
module tb_matrix_host_if;
  import macc_pkg::*;

  logic        CLK, RST;
  logic        cfg_valid, cfg_ready;
  logic [3:0]  cfg_row_idx_size, cfg_col_idx_size;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic [1:0]  rb_cnt;
  logic [15:0] rb_data;
  logic        we, re;
  logic [15:0] wr_data;
  logic [3:0]  row_idx_size, col_idx_size;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  matrix_host_if dut (
    .CLK              (CLK),
    .RST              (RST),
    .cfg_valid        (cfg_valid),
    .cfg_row_idx_size (cfg_row_idx_size),
    .cfg_col_idx_size (cfg_col_idx_size),
    .cfg_ready        (cfg_ready),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .m_valid          (m_valid),
    .m_data           (m_data),
    .m_ready          (m_ready),
    .rb_cnt           (rb_cnt),
    .rb_data          (rb_data),
    .we               (we),
    .re               (re),
    .wr_data          (wr_data),
    .row_idx_size     (row_idx_size),
    .col_idx_size     (col_idx_size),
    .busy             (busy),
    .done             (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] r, input logic [3:0] c);
    cfg_valid = 1'b1;
    cfg_row_idx_size = r;
    cfg_col_idx_size = c;
    #1;
    check("cfg_ready_idle", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    #1;
    check("state_load", dut.state, LOAD);
    check("row_size", row_idx_size, r);
    check("col_size", col_idx_size, c);
    check("busy_load", busy, 1);
  endtask

  task automatic do_write(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    check("s_ready", s_ready, 1);
    check("we", we, 1);
    check("wr_data", wr_data, d);
    check("re_in_load", re, 0);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] d);
    rb_cnt  = 2'd1;
    rb_data = d;
    m_ready = 1'b1;
    #1;
    check("m_valid", m_valid, 1);
    check("re", re, 1);
    check("m_data", m_data, d);
    check("we_in_unload", we, 0);
    tick();
    m_ready = 1'b0;
    rb_cnt  = 2'd0;
  endtask

  task automatic done_tail();
    #1;
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("state_idle", dut.state, IDLE);
    tick();
    check("done_cleared", done, 0);
  endtask

  initial begin
    RST = 1'b1;
    cfg_valid = 1'b0; cfg_row_idx_size = '0; cfg_col_idx_size = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; rb_cnt = '0; rb_data = '0;

    // Reset values
    #1;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_we", we, 0);
    check("rst_re", re, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_done", done, 0);
    check("rst_row", row_idx_size, 0);
    check("rst_col", col_idx_size, 0);
    #10 RST = 1'b0;
    tick();

    // 2x2 basic with read stall and host back-pressure
    do_cfg(4'd1, 4'd1);
    do_write(16'h0011);
    do_write(16'h0022);
    do_write(16'h0033);
    do_write(16'h0044);
    s_valid = 1'b1;
    #1;
    check("state_unload", dut.state, UNLOAD);
    check("we_after_4", we, 0);
    check("s_ready_unload", s_ready, 0);
    s_valid = 1'b0;

    rb_cnt = 2'd0;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_m_valid", m_valid, 0);
      check("stall_re", re, 0);
      tick();
    end
    rb_cnt = 2'd2;
    rb_data = 16'h0011;
    #1;
    check("unstall_re", re, 1);
    check("unstall_m_data", m_data, 16'h0011);
    tick();
    m_ready = 1'b0;
    rb_cnt = 2'd0;

    do_read(16'h0022);

    rb_cnt = 2'd2;
    rb_data = 16'h0033;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_m_valid", m_valid, 1);
      check("bp_re", re, 0);
      check("bp_m_data", m_data, 16'h0033);
      tick();
    end
    do_read(16'h0033);
    #1;
    check("done_early", done, 0);
    check("busy_mid", busy, 1);
    do_read(16'h0044);
    done_tail();

    // 1x1 matrix
    do_cfg(4'd0, 4'd0);
    do_write(16'hBEEF);
    #1;
    check("1x1_unload", dut.state, UNLOAD);
    do_read(16'hBEEF);
    done_tail();

    // Config offered during LOAD is ignored
    do_cfg(4'd1, 4'd1);
    cfg_valid = 1'b1;
    cfg_row_idx_size = 4'd3;
    cfg_col_idx_size = 4'd3;
    #1;
    check("cfg_ready_busy", cfg_ready, 0);
    do_write(16'h0001);
    #1;
    check("row_held", row_idx_size, 1);
    check("col_held", col_idx_size, 1);
    do_write(16'h0002);
    do_write(16'h0003);
    do_write(16'h0004);
    cfg_valid = 1'b0;
    #1;
    check("ign_unload_n4", dut.state, UNLOAD);
    do_read(16'h0001);
    do_read(16'h0002);
    do_read(16'h0003);
    do_read(16'h0004);
    done_tail();

    // Async reset mid-LOAD, then a clean transaction
    do_cfg(4'd1, 4'd1);
    do_write(16'h00AA);
    do_write(16'h00BB);
    RST = 1'b1;
    #2;
    check("arst_state", dut.state, IDLE);
    check("arst_s_ready", s_ready, 0);
    check("arst_cfg_ready", cfg_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_row", row_idx_size, 0);
    #1 RST = 1'b0;
    tick();
    do_cfg(4'd1, 4'd1);
    do_write(16'h1111);
    do_write(16'h2222);
    do_write(16'h3333);
    do_write(16'h4444);
    #1;
    check("post_rst_unload", dut.state, UNLOAD);
    do_read(16'h1111);
    do_read(16'h2222);
    do_read(16'h3333);
    do_read(16'h4444);
    done_tail();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
